// File: rtl/paddle_ctrl.sv
// Paddle controller: debounced active-low buttons or ball auto-tracking drive a
// paddle along [0, DRAW_W-BOARD_W], with step doubling while a direction is held.

module paddle_ctrl_deb #(
    parameter int DEB_N = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_lvl
);
    localparam int CW = (DEB_N > 1) ? $clog2(DEB_N) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_lvl;

    // The level only flips after DEB_N consecutive samples disagree with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_lvl <= 1'b1;
        end else if (i_raw == r_lvl) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEB_N - 1)) begin
            r_lvl <= i_raw;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_lvl = r_lvl;
endmodule

module paddle_ctrl #(
    parameter int DRAW_W     = 640,
    parameter int BOARD_W    = 100,
    parameter int BALL_W     = 100,
    parameter int POS_W      = 16,
    parameter int DEB_N      = 4,
    parameter int SPEED_MIN  = 1,
    parameter int SPEED_MAX  = 8,
    parameter int ACCEL_HOLD = 16,
    parameter int TRACK_DEAD = 4
) (
    input  logic             button_clk,
    input  logic             rst_n,
    input  logic             button_left,
    input  logic             button_right,
    input  logic             auto_en,
    input  logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] board_x,
    output logic [7:0]       speed,
    output logic [1:0]       dir_state,
    output logic             at_edge
);
    localparam int XMAX = DRAW_W - BOARD_W;
    localparam int HW   = $clog2(ACCEL_HOLD + 1);
    localparam logic [POS_W:0] XMAX_E     = (POS_W+1)'(XMAX);
    localparam logic [POS_W:0] HALF_BALL  = (POS_W+1)'(BALL_W / 2);
    localparam logic [POS_W:0] HALF_BOARD = (POS_W+1)'(BOARD_W / 2);
    localparam logic [POS_W:0] DEAD       = (POS_W+1)'(TRACK_DEAD);
    localparam logic [HW-1:0]  HOLD_LAST  = HW'(ACCEL_HOLD - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} dir_t;

    dir_t             r_dir;
    logic [POS_W-1:0] r_board_x;
    logic [7:0]       r_speed;
    logic [HW-1:0]    r_hold;

    logic [1:0]       w_raw;
    logic [1:0]       w_lvl;
    dir_t             w_cmd;
    logic [POS_W:0]   w_x_e;
    logic [POS_W:0]   w_ball_c;
    logic [POS_W:0]   w_tgt;
    logic [POS_W:0]   w_right_sum;
    logic [POS_W-1:0] w_spd_p;
    logic [POS_W-1:0] w_x_nxt;
    logic [8:0]       w_dbl;
    logic [7:0]       w_spd_up;

    assign w_raw = {button_right, button_left};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_deb
            paddle_ctrl_deb #(.DEB_N(DEB_N)) u_deb (
                .i_clk  (button_clk),
                .i_rst_n(rst_n),
                .i_raw  (w_raw[g]),
                .o_lvl  (w_lvl[g])
            );
        end
    endgenerate

    always_comb begin
        w_x_e    = {1'b0, r_board_x};
        // Centre the paddle under the ball; a target left of zero clamps to 0.
        w_ball_c = {1'b0, ball_x} + HALF_BALL;
        w_tgt    = (w_ball_c < HALF_BOARD) ? '0 : w_ball_c - HALF_BOARD;
        if (w_tgt > XMAX_E)
            w_tgt = XMAX_E;

        w_cmd = IDLE;
        if (auto_en) begin
            if (w_x_e + DEAD < w_tgt)
                w_cmd = RIGHT;
            else if (w_x_e > w_tgt + DEAD)
                w_cmd = LEFT;
        end else if (!w_lvl[0] && w_lvl[1]) begin
            w_cmd = LEFT;
        end else if (w_lvl[0] && !w_lvl[1]) begin
            w_cmd = RIGHT;
        end

        w_dbl    = {r_speed, 1'b0};
        w_spd_up = (w_dbl > 9'(SPEED_MAX)) ? 8'(SPEED_MAX) : w_dbl[7:0];

        w_spd_p     = POS_W'(r_speed);
        w_right_sum = w_x_e + {1'b0, w_spd_p};
        w_x_nxt     = r_board_x;
        case (r_dir)
            LEFT:    w_x_nxt = (r_board_x > w_spd_p) ? r_board_x - w_spd_p : '0;
            RIGHT:   w_x_nxt = (w_right_sum > XMAX_E) ? XMAX_E[POS_W-1:0] : w_right_sum[POS_W-1:0];
            default: w_x_nxt = r_board_x;
        endcase
    end

    always_ff @(posedge button_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir     <= IDLE;
            r_board_x <= POS_W'(XMAX / 2);
            r_speed   <= 8'(SPEED_MIN);
            r_hold    <= '0;
        end else begin
            r_dir     <= w_cmd;
            r_board_x <= w_x_nxt;
            if (w_cmd != r_dir || r_dir == IDLE) begin
                r_speed <= 8'(SPEED_MIN);
                r_hold  <= '0;
            end else if (r_hold == HOLD_LAST) begin
                r_speed <= w_spd_up;
                r_hold  <= '0;
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign board_x   = r_board_x;
    assign speed     = r_speed;
    assign dir_state = r_dir;
    assign at_edge   = (r_board_x == '0) || (w_x_e == XMAX_E);
endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter DRAW_W, default 640, drawable width in pixels.
REQ-002 SHALL have parameter BOARD_W, default 100, paddle width.
REQ-003 SHALL have parameter BALL_W, default 100, ball width, used only for auto-track centring.
REQ-004 SHALL have parameter POS_W, default 16, position bus width.
REQ-005 SHALL have parameter DEB_N, default 4, consecutive samples needed to accept a button level change (DEB_N >= 1).
REQ-006 SHALL have parameter SPEED_MIN, default 1, initial step in pixels per tick.
REQ-007 SHALL have parameter SPEED_MAX, default 8, step ceiling.
REQ-008 SHALL have parameter ACCEL_HOLD, default 16, ticks in one direction before the step doubles.
REQ-009 SHALL have parameter TRACK_DEAD, default 4, auto-track dead band in pixels.
REQ-010 SHALL have port button_clk, input, 1 bit: clock, rising edge, one tick per edge.
REQ-011 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-012 SHALL have port button_left, input, 1 bit: raw left button, active-low.
REQ-013 SHALL have port button_right, input, 1 bit: raw right button, active-low.
REQ-014 SHALL have port auto_en, input, 1 bit: 1 selects auto-track, 0 selects buttons.
REQ-015 SHALL have port ball_x, input, POS_W bits: ball left edge.
REQ-016 SHALL have port board_x, output, POS_W bits: paddle left edge.
REQ-017 SHALL have port speed, output, 8 bits: current step.
REQ-018 SHALL have port dir_state, output, 2 bits: 0 IDLE, 1 LEFT, 2 RIGHT.
REQ-019 SHALL have port at_edge, output, 1 bit: high when board_x == 0 or board_x == XMAX.

Function
REQ-020 SHALL define XMAX = DRAW_W - BOARD_W; board_x SHALL never leave [0, XMAX].
REQ-021 SHALL debounce each button with its own counter: a sample differing from the debounced level increments the counter; an equal sample clears it; on the DEB_N-th consecutive differing sample the debounced level flips and the counter clears.
REQ-022 SHALL, in manual mode, form the command from debounced levels: LEFT if only left is pressed, RIGHT if only right is pressed, IDLE if neither or both are pressed.
REQ-023 SHALL, in auto mode, compute target = ball_x + BALL_W/2 - BOARD_W/2 at width POS_W+1, clamped to [0, XMAX] (negative -> 0), and ignore the buttons.
REQ-024 SHALL, in auto mode, command RIGHT if board_x + TRACK_DEAD < target, LEFT if board_x > target + TRACK_DEAD, otherwise IDLE.
REQ-025 SHALL register the command into dir_state on every tick (one-tick latency).
REQ-026 SHALL, whenever the next dir_state differs from the current one, load speed = SPEED_MIN and clear the hold counter.
REQ-027 SHALL, while dir_state stays LEFT or RIGHT, increment the hold counter; when it reaches ACCEL_HOLD, set speed = min(2*speed, SPEED_MAX) and clear the counter.
REQ-028 SHALL hold speed at SPEED_MIN and the hold counter at 0 while in IDLE.
REQ-029 SHALL, on each tick with dir_state LEFT, update board_x to max(board_x - speed, 0), with no underflow.
REQ-030 SHALL, on each tick with dir_state RIGHT, update board_x to min(board_x + speed, XMAX), computed at width POS_W+1.
REQ-031 SHALL have an end-to-end latency from a raw press to the first board_x change of DEB_N + 2 ticks, counting the first low sample as tick 1.
REQ-032 SHALL treat an auto_en toggle mid-motion as a normal command change: the same direction continues accelerating, a different direction resets speed.
REQ-033 SHALL keep dir_state LEFT or RIGHT while clamped at a wall; board_x stays at the limit and at_edge = 1.

Reset
REQ-034 SHALL, on rst_n low at any time including mid-motion, immediately set board_x = XMAX/2 (270 with defaults), dir_state = IDLE, speed = SPEED_MIN, both hold and debounce counters = 0, and both debounced levels = released (1).
REQ-035 SHALL resume operation on the first rising button_clk edge after rst_n deasserts.

Verification
REQ-036 Bench SHALL check: reset asserted -> board_x = 270, dir_state = 0, speed = 1, at_edge = 0.
REQ-037 Bench SHALL check: button_left low for 3 ticks, then high -> board_x stays 270 and dir_state stays 0.
REQ-038 Bench SHALL check: button_left held low -> board_x = 269 after tick 6; speed = 2 after 16 ticks in LEFT; speed = 4 after 32 ticks; speed never exceeds 8.
REQ-039 Bench SHALL check: left held starting at board_x = 3 with speed = 4 -> board_x = 0 on the next step, then stays 0 with at_edge = 1 and dir_state = 1.
REQ-040 Bench SHALL check: both buttons debounced pressed -> dir_state = 0 and board_x unchanged; releasing right -> LEFT with speed = 1.
REQ-041 Bench SHALL check: auto_en = 1, ball_x = 500 -> target = 500, paddle moves right and stops with board_x in [496, 504]; ball_x = 0 -> target = 0, paddle reaches 0.
